// File: rtl/clint.sv
// -----------------------------------------------------------------------------
// clint -- core-local interruptor: machine timer (mtime/mtimecmp) and machine
// software interrupt (msip) registers behind a simple byte-addressed bus.
//
// Ports
//   clk                   clock, all state updates on its rising edge
//   rst                   asynchronous active-high reset
//   bus_clint_read_addr   read byte address (only [15:0] decoded)
//   bus_clint_read_size   read size in bytes (1, 2 or 4; others unmapped)
//   bus_clint_rd          read request, data returned one cycle later
//   bus_clint_write_addr  write byte address (only [15:0] decoded)
//   bus_clint_write_size  write size in bytes (1, 2 or 4; others unmapped)
//   bus_clint_data        write data, right-aligned
//   bus_clint_wr          write request, takes effect at the same edge
//   clint_bus_data        registered read data, right-aligned, zero-extended
//   clint_mtip            timer interrupt pending (mtime >= mtimecmp)
//   clint_msip            software interrupt pending (msip bit 0)
//   clint_mtime           current mtime value
//
// Register map (addr[15:0], word-selected with addr[1:0] cleared)
//   0x0000 msip, 0x4000/0x4004 mtimecmp lo/hi, 0xBFF8/0xBFFC mtime lo/hi
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif

module clint #(
    parameter int unsigned MTIME_DIV = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [`ADDR_WIDTH-1:0]       bus_clint_read_addr,
    input  logic [`SIZE_WIDTH-1:0]       bus_clint_read_size,
    input  logic                         bus_clint_rd,
    input  logic [`ADDR_WIDTH-1:0]       bus_clint_write_addr,
    input  logic [`SIZE_WIDTH-1:0]       bus_clint_write_size,
    input  logic [`REG_DATA_WIDTH-1:0]   bus_clint_data,
    input  logic                         bus_clint_wr,
    output logic [`BUS_DATA_WIDTH-1:0]   clint_bus_data,
    output logic                         clint_mtip,
    output logic                         clint_msip,
    output logic [63:0]                  clint_mtime
);

    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;
    localparam logic [15:0] PRESC_LAST   = 16'(MTIME_DIV - 1);

    // Byte-enable pattern for a right-aligned access of the given size;
    // all-zero marks an illegal size, which the decode treats as unmapped.
    function automatic logic [3:0] size_mask(input logic [`SIZE_WIDTH-1:0] size);
        logic [3:0] m;
        m = 4'b0000;
        if (size == `SIZE_WIDTH'(1)) m = 4'b0001;
        if (size == `SIZE_WIDTH'(2)) m = 4'b0011;
        if (size == `SIZE_WIDTH'(4)) m = 4'b1111;
        return m;
    endfunction

    // ---------------------------------------------------------------- state
    logic                        msip_q,     msip_d;
    logic [63:0]                 mtimecmp_q, mtimecmp_d;
    logic [63:0]                 mtime_q,    mtime_d;
    logic [15:0]                 presc_q,    presc_d;
    logic [`BUS_DATA_WIDTH-1:0]  rdata_q,    rdata_d;

    // Upper address bits are ignored by the decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus_clint_read_addr[`ADDR_WIDTH-1:16],
                                bus_clint_write_addr[`ADDR_WIDTH-1:16]};

    // ----------------------------------------------------------------- read
    logic [15:0] rd_word_off;
    logic [1:0]  rd_lane;
    logic [3:0]  rd_bytes;
    logic [31:0] rd_bit_mask;
    logic [31:0] rd_word;
    logic [31:0] rd_shifted;

    assign rd_word_off = {bus_clint_read_addr[15:2], 2'b00};
    assign rd_lane     = bus_clint_read_addr[1:0];
    assign rd_bytes    = size_mask(bus_clint_read_size);

    // ---------------------------------------------------------------- write
    logic [15:0] wr_word_off;
    logic [1:0]  wr_lane;
    logic [3:0]  wr_bytes;
    logic [3:0]  wr_byte_en;
    logic [31:0] wr_shifted;
    logic [31:0] wr_old_word;
    logic [31:0] wr_merged;
    logic        wr_valid;
    logic        wr_msip, wr_cmp_lo, wr_cmp_hi, wr_mtime_lo, wr_mtime_hi;

    assign wr_word_off = {bus_clint_write_addr[15:2], 2'b00};
    assign wr_lane     = bus_clint_write_addr[1:0];
    assign wr_bytes    = size_mask(bus_clint_write_size);
    assign wr_valid    = bus_clint_wr && (wr_bytes != 4'b0000);
    // Shifting into a 4-bit / 32-bit result drops bytes past the word end.
    assign wr_byte_en  = wr_valid ? 4'(wr_bytes << wr_lane) : 4'b0000;
    assign wr_shifted  = 32'(bus_clint_data << {wr_lane, 3'b000});

    assign wr_msip     = wr_valid && (wr_word_off == OFF_MSIP);
    assign wr_cmp_lo   = wr_valid && (wr_word_off == OFF_CMP_LO);
    assign wr_cmp_hi   = wr_valid && (wr_word_off == OFF_CMP_HI);
    assign wr_mtime_lo = wr_valid && (wr_word_off == OFF_MTIME_LO);
    assign wr_mtime_hi = wr_valid && (wr_word_off == OFF_MTIME_HI);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_bit_mask[8*gi +: 8] = {8{rd_bytes[gi]}};
            assign wr_merged[8*gi +: 8]   = wr_byte_en[gi] ? wr_shifted[8*gi +: 8]
                                                           : wr_old_word[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        rd_word = 32'h0;
        if (rd_bytes != 4'b0000) begin
            case (rd_word_off)
                OFF_MSIP:     rd_word = {31'h0, msip_q};
                OFF_CMP_LO:   rd_word = mtimecmp_q[31:0];
                OFF_CMP_HI:   rd_word = mtimecmp_q[63:32];
                OFF_MTIME_LO: rd_word = mtime_q[31:0];
                OFF_MTIME_HI: rd_word = mtime_q[63:32];
                default:      rd_word = 32'h0;
            endcase
        end
        rd_shifted = (rd_word >> {rd_lane, 3'b000}) & rd_bit_mask;
        rdata_d    = bus_clint_rd ? `BUS_DATA_WIDTH'(rd_shifted) : '0;
    end

    // Only one register can be selected per write, so a single merged word
    // serves every target.
    always_comb begin
        wr_old_word = 32'h0;
        case (wr_word_off)
            OFF_MSIP:     wr_old_word = {31'h0, msip_q};
            OFF_CMP_LO:   wr_old_word = mtimecmp_q[31:0];
            OFF_CMP_HI:   wr_old_word = mtimecmp_q[63:32];
            OFF_MTIME_LO: wr_old_word = mtime_q[31:0];
            OFF_MTIME_HI: wr_old_word = mtime_q[63:32];
            default:      wr_old_word = 32'h0;
        endcase
    end

    // -------------------------------------------------- timer / next state
    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = mtime_q;
        presc_d    = presc_q + 16'd1;

        if (presc_q == PRESC_LAST) begin
            presc_d = 16'd0;
        end

        if (wr_msip)   msip_d             = wr_merged[0];
        if (wr_cmp_lo) mtimecmp_d[31:0]   = wr_merged;
        if (wr_cmp_hi) mtimecmp_d[63:32]  = wr_merged;

        // A software write to mtime wins over the tick; the prescaler keeps
        // running regardless.
        if (wr_mtime_lo) begin
            mtime_d = {mtime_q[63:32], wr_merged};
        end else if (wr_mtime_hi) begin
            mtime_d = {wr_merged, mtime_q[31:0]};
        end else if (presc_q == PRESC_LAST) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip_q     <= 1'b0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtime_q    <= 64'h0;
            presc_q    <= 16'd0;
            rdata_q    <= '0;
        end else begin
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
            mtime_q    <= mtime_d;
            presc_q    <= presc_d;
            rdata_q    <= rdata_d;
        end
    end

    assign clint_bus_data = rdata_q;
    assign clint_mtip     = (mtime_q >= mtimecmp_q);
    assign clint_msip     = msip_q;
    assign clint_mtime    = mtime_q;

endmodule

// File: tb/tb_clint.sv
// -----------------------------------------------------------------------------
// tb_clint -- directed bench for clint. Two instances share one clock:
// dut (MTIME_DIV=1) and dut4 (MTIME_DIV=4). Inputs change 1 time unit after
// a rising edge; outputs are sampled at the same point after the next edge.
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif

module tb_clint;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // MTIME_DIV=1 instance
    logic                        rst = 1'b1;
    logic [`ADDR_WIDTH-1:0]      rd_addr = '0, wr_addr = '0;
    logic [`SIZE_WIDTH-1:0]      rd_size = '0, wr_size = '0;
    logic                        rd = 1'b0, wr = 1'b0;
    logic [`REG_DATA_WIDTH-1:0]  wr_data = '0;
    logic [`BUS_DATA_WIDTH-1:0]  bus_data;
    logic                        mtip, msip;
    logic [63:0]                 mtime;

    // MTIME_DIV=4 instance
    logic                        rst4 = 1'b1;
    logic [`ADDR_WIDTH-1:0]      rd_addr4 = '0, wr_addr4 = '0;
    logic [`SIZE_WIDTH-1:0]      rd_size4 = '0, wr_size4 = '0;
    logic                        rd4 = 1'b0, wr4 = 1'b0;
    logic [`REG_DATA_WIDTH-1:0]  wr_data4 = '0;
    logic [`BUS_DATA_WIDTH-1:0]  bus_data4;
    logic                        mtip4, msip4;
    logic [63:0]                 mtime4;

    clint #(.MTIME_DIV(1)) dut (
        .clk(clk), .rst(rst),
        .bus_clint_read_addr(rd_addr), .bus_clint_read_size(rd_size), .bus_clint_rd(rd),
        .bus_clint_write_addr(wr_addr), .bus_clint_write_size(wr_size),
        .bus_clint_data(wr_data), .bus_clint_wr(wr),
        .clint_bus_data(bus_data), .clint_mtip(mtip), .clint_msip(msip), .clint_mtime(mtime)
    );

    clint #(.MTIME_DIV(4)) dut4 (
        .clk(clk), .rst(rst4),
        .bus_clint_read_addr(rd_addr4), .bus_clint_read_size(rd_size4), .bus_clint_rd(rd4),
        .bus_clint_write_addr(wr_addr4), .bus_clint_write_size(wr_size4),
        .bus_clint_data(wr_data4), .bus_clint_wr(wr4),
        .clint_bus_data(bus_data4), .clint_mtip(mtip4), .clint_msip(msip4), .clint_mtime(mtime4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int sel, input logic [`ADDR_WIDTH-1:0] addr,
                             input logic [`SIZE_WIDTH-1:0] size,
                             input logic [`REG_DATA_WIDTH-1:0] data);
        if (sel == 0) begin
            wr_addr = addr; wr_size = size; wr_data = data; wr = 1'b1;
        end else begin
            wr_addr4 = addr; wr_size4 = size; wr_data4 = data; wr4 = 1'b1;
        end
        step();
        wr = 1'b0;
        wr4 = 1'b0;
        $display("WR  dut%0d addr=0x%04h size=%0d data=0x%08h", sel, addr[15:0], size, data);
    endtask

    task automatic bus_read(input int sel, input logic [`ADDR_WIDTH-1:0] addr,
                            input logic [`SIZE_WIDTH-1:0] size,
                            output logic [`BUS_DATA_WIDTH-1:0] data);
        if (sel == 0) begin
            rd_addr = addr; rd_size = size; rd = 1'b1;
        end else begin
            rd_addr4 = addr; rd_size4 = size; rd4 = 1'b1;
        end
        step();
        data = (sel == 0) ? bus_data : bus_data4;
        rd = 1'b0;
        rd4 = 1'b0;
        $display("RD  dut%0d addr=0x%04h size=%0d data=0x%08h", sel, addr[15:0], size, data);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [`BUS_DATA_WIDTH-1:0] d;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_mtime", mtime, 64'h0);
        check("rst_mtip", {63'h0, mtip}, 64'h0);
        check("rst_msip", {63'h0, msip}, 64'h0);
        check("rst_bus_data", {32'h0, bus_data}, 64'h0);
        rst = 1'b0;

        // Free-running count, no requests
        repeat (10) step();
        check("idle_mtime", mtime, 64'd10);
        check("idle_mtip", {63'h0, mtip}, 64'h0);
        check("idle_msip", {63'h0, msip}, 64'h0);
        check("idle_bus_data", {32'h0, bus_data}, 64'h0);

        // msip
        bus_write(0, 32'h0000, 3'd4, 32'h1);
        check("msip_set", {63'h0, msip}, 64'h1);
        check("msip_mtime_counts", mtime, 64'd11);
        bus_read(0, 32'h0000, 3'd1, d);
        check("msip_byte_read", {32'h0, d}, 64'h01);
        step();
        check("rd_idle_zero", {32'h0, bus_data}, 64'h0);
        bus_write(0, 32'h0000, 3'd4, 32'hFFFF_FFFF);
        bus_read(0, 32'h0000, 3'd4, d);
        check("msip_upper_bits_zero", {32'h0, d}, 64'h1);
        bus_write(0, 32'h0000, 3'd4, 32'h0);
        check("msip_clear", {63'h0, msip}, 64'h0);

        // Timer compare
        bus_write(0, 32'hBFF8, 3'd4, 32'd5);
        check("mtime_lo_write", mtime, 64'd5);
        bus_write(0, 32'h4004, 3'd4, 32'h0);
        bus_write(0, 32'h4000, 3'd4, 32'd20);
        check("cmp_mtime_7", mtime, 64'd7);
        check("mtip_low_before", {63'h0, mtip}, 64'h0);
        repeat (12) step();
        check("cmp_mtime_19", mtime, 64'd19);
        check("mtip_low_at_19", {63'h0, mtip}, 64'h0);
        step();
        check("cmp_mtime_20", mtime, 64'd20);
        check("mtip_high_at_20", {63'h0, mtip}, 64'h1);
        bus_write(0, 32'h4004, 3'd4, 32'hFFFF_FFFF);
        check("mtip_cleared", {63'h0, mtip}, 64'h0);

        // Carry across halves, byte/halfword reads of mtime
        bus_write(0, 32'hBFF8, 3'd4, 32'hFFFF_FFFE);
        bus_write(0, 32'hBFFC, 3'd4, 32'h0);
        check("mtime_merged", mtime, 64'h0000_0000_FFFF_FFFE);
        repeat (2) step();
        check("mtime_carry", mtime, 64'h1_0000_0000);
        bus_read(0, 32'hBFFC, 3'd1, d);
        check("mtime_hi_byte", {32'h0, d}, 64'h01);
        bus_read(0, 32'hBFFA, 3'd2, d);
        check("mtime_lo_half_hi", {32'h0, d}, 64'h0000);

        // 64-bit wrap
        bus_write(0, 32'hBFF8, 3'd4, 32'hFFFF_FFFF);
        check("mtime_lo_merge_keep_hi", mtime, 64'h1_FFFF_FFFF);
        bus_write(0, 32'hBFFC, 3'd4, 32'hFFFF_FFFF);
        check("mtime_all_ones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        check("mtime_wrap", mtime, 64'h0);

        // Same-cycle read/write, partial writes, unmapped and illegal sizes
        bus_write(0, 32'h4000, 3'd4, 32'hFFFF_FFFF);
        rd_addr = 32'h4000; rd_size = 3'd4; rd = 1'b1;
        wr_addr = 32'h4000; wr_size = 3'd4; wr_data = 32'h1234; wr = 1'b1;
        step();
        rd = 1'b0; wr = 1'b0;
        $display("RW  dut0 addr=0x4000 size=4 wdata=0x00001234 rdata=0x%08h", bus_data);
        check("rw_same_cycle_old", {32'h0, bus_data}, 64'hFFFF_FFFF);
        bus_read(0, 32'h4000, 3'd4, d);
        check("rw_new_value", {32'h0, d}, 64'h0000_1234);
        bus_write(0, 32'h4003, 3'd2, 32'hABCD);
        bus_read(0, 32'h4000, 3'd4, d);
        check("half_write_byte3", {32'h0, d}, 64'hCD00_1234);
        bus_read(0, 32'h4004, 3'd4, d);
        check("half_write_dropped", {32'h0, d}, 64'hFFFF_FFFF);
        bus_write(0, 32'h4001, 3'd1, 32'hFFFF_FF77);
        bus_read(0, 32'h4000, 3'd4, d);
        check("byte_write_lane1", {32'h0, d}, 64'hCD00_7734);
        bus_write(0, 32'h4000, 3'd3, 32'h0);
        bus_read(0, 32'h4000, 3'd4, d);
        check("illegal_size_write", {32'h0, d}, 64'hCD00_7734);
        bus_read(0, 32'h4000, 3'd3, d);
        check("illegal_size_read", {32'h0, d}, 64'h0);
        bus_write(0, 32'h1000, 3'd4, 32'hDEAD_BEEF);
        bus_read(0, 32'h1000, 3'd4, d);
        check("unmapped_read", {32'h0, d}, 64'h0);
        bus_read(0, 32'h4004, 3'd2, d);
        check("cmp_hi_half", {32'h0, d}, 64'hFFFF);

        // MTIME_DIV=4 instance
        rst4 = 1'b0;
        repeat (3) step();
        check("div4_mtime_3cyc", mtime4, 64'd0);
        step();
        check("div4_mtime_4cyc", mtime4, 64'd1);
        repeat (4) step();
        check("div4_mtime_8cyc", mtime4, 64'd2);
        repeat (3) step();
        bus_write(1, 32'hBFF8, 3'd4, 32'h100);
        check("div4_write_suppress", mtime4, 64'h100);
        repeat (3) step();
        check("div4_hold", mtime4, 64'h100);
        step();
        check("div4_presc_continues", mtime4, 64'h101);
        bus_read(1, 32'h8000, 3'd4, d);
        check("div4_unmapped", {32'h0, d}, 64'h0);
        rd_addr4 = 32'hBFF8; rd_size4 = 3'd4; rd4 = 1'b1;
        step();
        $display("RD  dut4 addr=0xbff8 size=4 data=0x%08h", bus_data4);
        check("div4_read_before_rst", {32'h0, bus_data4}, 64'h101);
        #2;
        rst4 = 1'b1;
        #1;
        check("div4_rst_bus_data", {32'h0, bus_data4}, 64'h0);
        check("div4_rst_mtime", mtime4, 64'h0);
        check("div4_rst_mtip", {63'h0, mtip4}, 64'h0);
        check("div4_rst_msip", {63'h0, msip4}, 64'h0);
        step();
        rd4 = 1'b0;
        rst4 = 1'b0;
        step();
        check("div4_after_rst_data", {32'h0, bus_data4}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
